// File: rtl/load_store_unit_if.sv
// Pipeline request/response and word-addressed data memory signals of the load/store unit.
interface load_store_unit_if;
   logic        req_valid;
   logic        req_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        req_ready;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] mem_address;
   logic [31:0] mem_datain;
   logic        mem_wen;
   logic        mem_ren;
   logic [3:0]  mem_byte_selector;
   logic [31:0] mem_dataout;
   logic        mem_memsig;

   // Load/store unit view: accepts requests, drives the memory port.
   modport slave (
      input  req_valid, req_store, req_funct3, req_addr, req_wdata,
      input  mem_dataout, mem_memsig,
      output req_ready, resp_valid, resp_rdata, resp_err,
      output mem_address, mem_datain, mem_wen, mem_ren, mem_byte_selector
   );

   // Environment view: pipeline issuing requests plus memory answering reads.
   modport master (
      output req_valid, req_store, req_funct3, req_addr, req_wdata,
      output mem_dataout, mem_memsig,
      input  req_ready, resp_valid, resp_rdata, resp_err,
      input  mem_address, mem_datain, mem_wen, mem_ren, mem_byte_selector
   );
endinterface

// File: rtl/load_store_unit.sv
// RV32 load/store unit: one request becomes a single ren or wen word access with lane enables.
module load_store_unit #(
   parameter int unsigned MEM_WORDS      = 1024,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic             clk,
   input  logic             rst,
   load_store_unit_if.slave bus
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR, RESP} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2:0]         f3_q, f3_d;
   logic [1:0]         off_q, off_d;
   logic               err_q, err_d;

   logic               req_ready_q, req_ready_d;
   logic               resp_valid_q, resp_valid_d;
   logic [31:0]        resp_rdata_q, resp_rdata_d;
   logic               resp_err_q, resp_err_d;
   logic [31:0]        mem_address_q, mem_address_d;
   logic [31:0]        mem_datain_q, mem_datain_d;
   logic               mem_wen_q, mem_wen_d;
   logic               mem_ren_q, mem_ren_d;
   logic [3:0]         mem_sel_q, mem_sel_d;

   logic               f3_ok_c;
   logic               align_ok_c;
   logic               range_ok_c;
   logic               req_bad_c;
   logic [3:0]         st_sel_c;
   logic [31:0]        st_data_c;
   logic [7:0]         ld_byte_c;
   logic [15:0]        ld_half_c;
   logic [31:0]        ld_data_c;

   // Request validation and store lane/data formatting from the live request.
   always_comb begin
      if (bus.req_store) begin
         f3_ok_c = bus.req_funct3 inside {3'b000, 3'b001, 3'b010};
      end else begin
         f3_ok_c = bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      end

      case (bus.req_funct3[1:0])
         2'b01:   align_ok_c = ~bus.req_addr[0];
         2'b10:   align_ok_c = (bus.req_addr[1:0] == 2'b00);
         default: align_ok_c = 1'b1;
      endcase

      range_ok_c = ({2'b00, bus.req_addr[31:2]} < 32'(MEM_WORDS));
      req_bad_c  = ~(f3_ok_c & align_ok_c & range_ok_c);

      case (bus.req_funct3[1:0])
         2'b00: begin
            st_sel_c  = 4'b0001 << bus.req_addr[1:0];
            st_data_c = {4{bus.req_wdata[7:0]}};
         end
         2'b01: begin
            st_sel_c  = 4'b0011 << bus.req_addr[1:0];
            st_data_c = {2{bus.req_wdata[15:0]}};
         end
         default: begin
            st_sel_c  = 4'b1111;
            st_data_c = bus.req_wdata;
         end
      endcase
   end

   // Load extraction from the returned word using the latched width code and byte offset.
   always_comb begin
      ld_byte_c = 8'(bus.mem_dataout >> {off_q, 3'b000});
      ld_half_c = off_q[1] ? bus.mem_dataout[31:16] : bus.mem_dataout[15:0];
      case (f3_q)
         3'b000:  ld_data_c = {{24{ld_byte_c[7]}}, ld_byte_c};
         3'b100:  ld_data_c = {24'h000000, ld_byte_c};
         3'b001:  ld_data_c = {{16{ld_half_c[15]}}, ld_half_c};
         3'b101:  ld_data_c = {16'h0000, ld_half_c};
         default: ld_data_c = bus.mem_dataout;
      endcase
   end

   // Next-state and next-output logic; every output is the registered copy of its _d value.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      f3_d          = f3_q;
      off_d         = off_q;
      err_d         = err_q;
      mem_address_d = mem_address_q;
      mem_datain_d  = mem_datain_q;
      mem_sel_d     = mem_sel_q;
      mem_wen_d     = 1'b0;
      mem_ren_d     = 1'b0;
      resp_valid_d  = 1'b0;
      resp_err_d    = 1'b0;
      resp_rdata_d  = 32'h0000_0000;

      unique case (state_q)
         IDLE: begin
            if (bus.req_valid && req_ready_q) begin
               f3_d          = bus.req_funct3;
               off_d         = bus.req_addr[1:0];
               err_d         = req_bad_c;
               mem_address_d = {2'b00, bus.req_addr[31:2]};
               cnt_d         = '0;
               if (req_bad_c) begin
                  // Rejected requests pass one strobe-free cycle in WR so they answer like a store.
                  state_d = WR;
               end else if (bus.req_store) begin
                  state_d      = WR;
                  mem_wen_d    = 1'b1;
                  mem_sel_d    = st_sel_c;
                  mem_datain_d = st_data_c;
               end else begin
                  state_d   = RD_REQ;
                  mem_ren_d = 1'b1;
                  mem_sel_d = 4'b1111;
               end
            end
         end
         RD_REQ: begin
            state_d = RD_WAIT;
            cnt_d   = '0;
         end
         RD_WAIT: begin
            if (bus.mem_memsig) begin
               state_d      = RESP;
               resp_valid_d = 1'b1;
               resp_rdata_d = ld_data_c;
               cnt_d        = '0;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               state_d      = RESP;
               resp_valid_d = 1'b1;
               resp_err_d   = 1'b1;
               cnt_d        = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         WR: begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = err_q;
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      req_ready_d = (state_d == IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         f3_q          <= 3'b000;
         off_q         <= 2'b00;
         err_q         <= 1'b0;
         req_ready_q   <= 1'b1;
         resp_valid_q  <= 1'b0;
         resp_rdata_q  <= 32'h0000_0000;
         resp_err_q    <= 1'b0;
         mem_address_q <= 32'h0000_0000;
         mem_datain_q  <= 32'h0000_0000;
         mem_wen_q     <= 1'b0;
         mem_ren_q     <= 1'b0;
         mem_sel_q     <= 4'b0000;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         f3_q          <= f3_d;
         off_q         <= off_d;
         err_q         <= err_d;
         req_ready_q   <= req_ready_d;
         resp_valid_q  <= resp_valid_d;
         resp_rdata_q  <= resp_rdata_d;
         resp_err_q    <= resp_err_d;
         mem_address_q <= mem_address_d;
         mem_datain_q  <= mem_datain_d;
         mem_wen_q     <= mem_wen_d;
         mem_ren_q     <= mem_ren_d;
         mem_sel_q     <= mem_sel_d;
      end
   end

   assign bus.req_ready         = req_ready_q;
   assign bus.resp_valid        = resp_valid_q;
   assign bus.resp_rdata        = resp_rdata_q;
   assign bus.resp_err          = resp_err_q;
   assign bus.mem_address       = mem_address_q;
   assign bus.mem_datain        = mem_datain_q;
   assign bus.mem_wen           = mem_wen_q;
   assign bus.mem_ren           = mem_ren_q;
   assign bus.mem_byte_selector = mem_sel_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-level reference memory, word memory model, decoupled monitor.
module tb_load_store_unit;

   localparam int unsigned MEM_WORDS      = 1024;
   localparam int unsigned TIMEOUT_CYCLES = 16;
   localparam int unsigned AW             = $clog2(MEM_WORDS);
   localparam int unsigned BW             = $clog2(4 * MEM_WORDS);

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } resp_t;

   typedef struct {
      logic        wr;
      logic [31:0] idx;
      logic [3:0]  sel;
      logic [31:0] data;
   } acc_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic suppress = 1'b0;
   logic stray = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   resp_t exp_q[$];
   acc_t  mem_q[$];
   time   acc_q[$];

   logic [31:0] mem_words [MEM_WORDS];
   logic [7:0]  ref_b [4*MEM_WORDS];

   load_store_unit_if bus();

   load_store_unit #(
      .MEM_WORDS      (MEM_WORDS),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Word memory behind the port: lane writes on wen, read data plus memsig one cycle after ren.
   always @(posedge clk) begin
      logic [AW-1:0] widx;
      widx = bus.mem_address[AW-1:0];
      if (rst) begin
         bus.mem_memsig  <= 1'b0;
         bus.mem_dataout <= 32'h0;
      end else begin
         if (bus.mem_wen && bus.mem_address < 32'(MEM_WORDS)) begin
            for (int k = 0; k < 4; k++)
               if (bus.mem_byte_selector[k]) mem_words[widx][8*k +: 8] = bus.mem_datain[8*k +: 8];
         end
         bus.mem_memsig <= (bus.mem_ren && !suppress) || stray;
         if (bus.mem_ren && bus.mem_address < 32'(MEM_WORDS)) bus.mem_dataout <= mem_words[widx];
      end
   end

   // Records the time of every accept edge for latency measurement.
   always @(posedge clk) begin
      if (!rst && bus.req_valid && bus.req_ready) acc_q.push_back($time);
   end

   // Monitor: checks strobes and responses against the queued expectations.
   always @(negedge clk) begin
      if (bus.mem_wen || bus.mem_ren) begin
         check("strobe_exclusive", 32'(bus.mem_wen & bus.mem_ren), 32'h0);
         if (mem_q.size() == 0) begin
            check("unexpected_strobe", 32'(1), 32'(0));
         end else begin
            acc_t e;
            e = mem_q.pop_front();
            check("strobe_kind_wen", 32'(bus.mem_wen), 32'(e.wr));
            check("mem_address", bus.mem_address, e.idx);
            check("mem_byte_selector", 32'(bus.mem_byte_selector), 32'(e.sel));
            if (e.wr) check("mem_datain", bus.mem_datain, e.data);
         end
      end
      if (bus.resp_valid) begin
         if (exp_q.size() == 0 || acc_q.size() == 0) begin
            check("unexpected_resp", 32'(1), 32'(0));
         end else begin
            resp_t r;
            time   ta;
            r  = exp_q.pop_front();
            ta = acc_q.pop_front();
            check("resp_rdata", bus.resp_rdata, r.rdata);
            check("resp_err", 32'(bus.resp_err), 32'(r.err));
            check("resp_latency", 32'(($time - ta - 5) / 10), 32'(r.lat));
            check("ready_low_in_resp", 32'(bus.req_ready), 32'h0);
         end
      end
   end

   // Issue one request; expectations come from the byte-level reference model.
   task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic sup);
      int          w;
      int          nb;
      longint      a;
      longint      x;
      logic        legal;
      logic        ok;
      logic [3:0]  sel;
      logic [31:0] d;
      resp_t       r;
      acc_t        m;
      w = 0;
      while (!bus.req_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (!bus.req_ready) check("req_ready_timeout", 32'(bus.req_ready), 32'h1);
      case (f3[1:0])
         2'b00:   nb = 1;
         2'b01:   nb = 2;
         2'b10:   nb = 4;
         default: nb = 0;
      endcase
      a     = longint'(addr);
      legal = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      ok    = legal && nb != 0 && (a % nb) == 0 && a < longint'(4 * MEM_WORDS);
      if (!ok) begin
         r = '{rdata: 32'h0, err: 1'b1, lat: 1};
      end else if (st) begin
         sel = 4'b0000;
         for (int b = 0; b < nb; b++) begin
            sel = sel | 4'(1 << ((a % 4) + b));
            ref_b[BW'(a + b)] = wd[8*b +: 8];
         end
         for (int j = 0; j < 4; j++) d[8*j +: 8] = wd[8*(j % nb) +: 8];
         m = '{wr: 1'b1, idx: 32'(a / 4), sel: sel, data: d};
         mem_q.push_back(m);
         r = '{rdata: 32'h0, err: 1'b0, lat: 1};
      end else begin
         m = '{wr: 1'b0, idx: 32'(a / 4), sel: 4'hF, data: 32'h0};
         mem_q.push_back(m);
         if (sup) begin
            r = '{rdata: 32'h0, err: 1'b1, lat: 1 + int'(TIMEOUT_CYCLES)};
         end else begin
            x = 0;
            for (int b = 0; b < nb; b++) x = x + (longint'(ref_b[BW'(a + b)]) << (8 * b));
            if (!f3[2] && nb < 4 && x >= (longint'(1) << (8 * nb - 1))) x = x - (longint'(1) << (8 * nb));
            r = '{rdata: 32'(x), err: 1'b0, lat: 2};
         end
      end
      exp_q.push_back(r);
      suppress       = sup;
      bus.req_valid  = 1'b1;
      bus.req_store  = st;
      bus.req_funct3 = f3;
      bus.req_addr   = addr;
      bus.req_wdata  = wd;
      @(negedge clk);
      bus.req_valid  = 1'b0;
   endtask

   initial begin
      bus.req_valid  = 1'b0;
      bus.req_store  = 1'b0;
      bus.req_funct3 = 3'b000;
      bus.req_addr   = 32'h0;
      bus.req_wdata  = 32'h0;
      for (int i = 0; i < int'(MEM_WORDS); i++) begin
         mem_words[i] = $urandom;
         for (int j = 0; j < 4; j++) ref_b[4*i + j] = mem_words[i][8*j +: 8];
      end

      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_req_ready", 32'(bus.req_ready), 32'h1);
      check("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
      check("rst_resp_err", 32'(bus.resp_err), 32'h0);
      check("rst_resp_rdata", bus.resp_rdata, 32'h0);
      check("rst_mem_wen", 32'(bus.mem_wen), 32'h0);
      check("rst_mem_ren", 32'(bus.mem_ren), 32'h0);
      check("rst_mem_address", bus.mem_address, 32'h0);
      check("rst_mem_datain", bus.mem_datain, 32'h0);
      check("rst_mem_sel", 32'(bus.mem_byte_selector), 32'h0);

      issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0);
      issue(1'b1, 3'b000, 32'h13, 32'h000000A5, 1'b0);
      issue(1'b0, 3'b000, 32'h13, 32'h0, 1'b0);
      issue(1'b0, 3'b100, 32'h13, 32'h0, 1'b0);
      issue(1'b1, 3'b010, 32'h10, 32'h80017FFF, 1'b0);
      issue(1'b0, 3'b001, 32'h12, 32'h0, 1'b0);
      issue(1'b0, 3'b101, 32'h10, 32'h0, 1'b0);
      issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
      issue(1'b0, 3'b010, 32'h11, 32'h0, 1'b0);
      issue(1'b1, 3'b001, 32'h13, 32'h1234, 1'b0);
      issue(1'b0, 3'b011, 32'h10, 32'h0, 1'b0);
      issue(1'b0, 3'b010, 32'h1000, 32'h0, 1'b0);
      issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b1);

      // Reset while a load sits in RD_WAIT, then a stray memsig in IDLE.
      issue(1'b0, 3'b010, 32'h14, 32'h0, 1'b1);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      acc_q.delete();
      check("midrst_req_ready", 32'(bus.req_ready), 32'h1);
      check("midrst_mem_ren", 32'(bus.mem_ren), 32'h0);
      check("midrst_resp_valid", 32'(bus.resp_valid), 32'h0);
      check("midrst_no_pending_access", 32'(mem_q.size()), 32'h0);
      stray = 1'b1;
      @(negedge clk);
      stray = 1'b0;
      repeat (3) @(negedge clk);
      check("stray_ready", 32'(bus.req_ready), 32'h1);
      issue(1'b1, 3'b010, 32'h20, 32'hCAFEF00D, 1'b0);
      issue(1'b0, 3'b010, 32'h20, 32'h0, 1'b0);

      for (int n = 0; n < 300; n++) begin
         logic [31:0] ad;
         int          r;
         r = int'($urandom_range(0, 19));
         if (r == 0)      ad = 32'(4096 + $urandom_range(0, 63));
         else if (r == 1) ad = 32'(4092 + $urandom_range(0, 3));
         else if (r == 2) ad = $urandom;
         else             ad = 32'($urandom_range(0, 63));
         issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ad, $urandom,
               1'($urandom_range(0, 24) == 0));
      end

      for (int w = 0; w < 100 && exp_q.size() != 0; w++) @(negedge clk);
      repeat (3) @(negedge clk);
      check("drain_resp", 32'(exp_q.size()), 32'h0);
      check("drain_access", 32'(mem_q.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the word-addressed data memory port.
- Sits in the MEM stage between the pipeline and memory_d.
- Turns one RV32 load/store request (byte address, funct3, store data) into a single ren or wen access, including word index, byte_selector and replicated store data.
- For loads, waits for memsig, then extracts and sign/zero-extends the addressed byte, half or word and returns a one-cycle response.

Parameters:
- MEM_WORDS, 1024, number of 32-bit words behind the port; word index >= MEM_WORDS is an error.
- TIMEOUT_CYCLES, 16, RD_WAIT cycles allowed without memsig before a load is aborted with an error.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_store  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32 width code: LB=000, LH=001, LW=010, LBU=100, LHU=101, SB=000, SH=001, SW=010
- req_addr  input  32  byte address
- req_wdata  input  32  store data, LSB-aligned
- req_ready  output  1  high only in IDLE; request accepted at an edge where req_valid && req_ready
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  32  extended load data; 0 for stores and errors
- resp_err  output  1  misaligned, illegal funct3, out of range, or timeout; valid with resp_valid
- mem_address  output  32  word index = req_addr[31:2]
- mem_datain  output  32  replicated store data
- mem_wen  output  1  write strobe
- mem_ren  output  1  read strobe
- mem_byte_selector  output  4  lane enables; bit k covers bits [8k+7:8k]
- mem_dataout  input  32  read word from memory
- mem_memsig  input  1  read-data-valid pulse from memory

Behaviour:
- All outputs are registered.
- Reset values: req_ready=1 (state IDLE); resp_valid, resp_err, mem_wen, mem_ren = 0; mem_address, mem_datain, resp_rdata, mem_byte_selector = 0; timeout counter = 0.
- States: IDLE, RD_REQ, RD_WAIT, WR, RESP.
- IDLE, on accept edge E0, validate the request:
  - Half accesses need addr[0]=0; word accesses need addr[1:0]=00.
  - Store funct3 must be 000/001/010; load funct3 must be 000/001/010/100/101.
  - Word index must be < MEM_WORDS.
  - Any violation: go to RESP with err=1 and no memory strobe.
- Load path:
  - RD_REQ: mem_ren=1 for exactly one cycle, mem_byte_selector=1111.
  - RD_WAIT: mem_ren=0, counter increments each cycle.
  - On an edge with mem_memsig=1: capture mem_dataout, extract, go to RESP.
  - On counter reaching TIMEOUT_CYCLES: go to RESP with err=1, rdata=0.
  - Nominal sequence: ren high during cycle E0..E1, memsig seen at E2, resp_valid high during E2..E3.
  - Load latency is 2 cycles from the accept edge.
- Store path, WR state, one cycle:
  - mem_wen=1, mem_ren=0; return to RESP at E1.
  - Store latency is 1 cycle.
  - Memory gives no acknowledge for stores; the store is complete at E1.
- Store lane mapping, with k = addr[1:0]:
  - SB: sel = 0001<<k, datain = {4{wdata[7:0]}}.
  - SH: sel = 0011<<k, datain = {2{wdata[15:0]}}.
  - SW: sel = 1111, datain = wdata.
- Load extraction:
  - LB/LBU: lane k, sign- or zero-extended.
  - LH/LHU: bits [16*addr[1]+15 : 16*addr[1]], extended.
  - LW: full word.
- RESP:
  - resp_valid=1 for one cycle; req_ready=0 in this state.
  - mem_wen and mem_ren are never both high; neither is high outside RD_REQ/WR.
  - Next state is IDLE; a new request can be accepted the following cycle.
- A mem_memsig pulse arriving outside RD_WAIT is ignored.
- rst mid-operation (any state): next edge returns to IDLE with reset values, strobes drop immediately, no resp_valid for the aborted request.
- A store is in memory only if its WR cycle completed before rst.

Test Plan:
- SW addr 0x10, wdata 0xDEADBEEF -> mem_address=4, sel=1111, wen high 1 cycle; resp_valid 1 cycle after accept, err=0.
- SB addr 0x13, wdata 0x000000A5 -> sel=1000, mem_datain=0xA5A5A5A5. Then LB 0x13 -> rdata 0xFFFFFFA5; LBU 0x13 -> 0x000000A5; each resp_valid 2 cycles after accept.
- Memory word 4 = 0x8001_7FFF: LH 0x12 -> 0xFFFF8001; LHU 0x10 -> 0x00007FFF; LW 0x10 -> 0x80017FFF.
- LW addr 0x11, SH addr 0x13, funct3 011 load -> resp_err=1, resp_valid 1 cycle after accept, no ren/wen ever asserted.
- LW addr 0x1000 (index 1024) -> err with no strobe. Bench memory model suppresses memsig on a valid LW -> err after 16 RD_WAIT cycles, rdata=0, req_ready returns.
- rst asserted during RD_WAIT -> state IDLE next edge, ren=0, no resp_valid. A stray memsig one cycle later is ignored. A following SW completes normally.
